traffic_light_ctrl: RTL and testbench
=====================================

// Module: traffic_light_ctrl
// PURPOSE
//  Single-direction traffic light sequencer; drives the LED/7-seg display decoder.
//  Cycles GREEN -> YELLOW -> RED -> GREEN, dwelling a parameterised number of seconds in each phase.
//  Outputs one-hot lamp bits plus a two-digit BCD countdown of the seconds remaining in the phase.
//  Derives its 1 s tick internally from the system clock.
// PARAMETERS
//  CLK_PER_SEC  50_000_000  clock cycles per second tick (>=2)
//  T_GREEN      25          green dwell, seconds (1..99)
//  T_YELLOW     3           yellow dwell, seconds (1..99)
//  T_RED        30          red dwell, seconds (1..99)
// PORTS
//  clk              in   1  system clock, rising edge
//  rst_n            in   1  asynchronous reset, active low
//  enable           in   1  1 = run; 0 = freeze prescaler, FSM and outputs
//  nightMode        in   1  night request (used only with NIGHT_MODE_EN)
//  ledSingle        out  3  {green,yellow,red} lamp drive, registered
//  controlLed7Seg1  out  4  BCD tens digit of remaining seconds, registered
//  controlLed7Seg0  out  4  BCD units digit of remaining seconds, registered
//  secTick          out  1  1-cycle pulse at each second boundary, registered
// BEHAVIOUR
//  - Reset (async assert, sync release): state=GREEN, prescaler=0, ledSingle=3'b100,
//    digits = BCD(T_GREEN), secTick=0, internal yellow blink flag=0.
//  - Prescaler: counts 0..CLK_PER_SEC-1 while enable=1 and wraps to 0.
//    secTick=1 on the cycle following prescaler==CLK_PER_SEC-1 with enable=1.
//  - The FSM acts on the same clock edge that raises secTick. Its events are
//    "tick" = (prescaler==CLK_PER_SEC-1 && enable).
//  - States and lamps:
//    GREEN = 3'b100, YELLOW = 3'b010, RED = 3'b001.
//    Exactly one lamp is on outside NIGHT.
//  - Countdown: the display shows the phase dwell T first, then T-1, ..., 1, one value per tick.
//  - On a tick with the display at 01:
//    - Advance the state: GREEN->YELLOW, YELLOW->RED, RED->GREEN.
//    - Load BCD(next phase T) into the digits.
//    - Lamps and digits change on the same edge.
//  - BCD decrement: if units==0, units=9 and tens=tens-1; else units=units-1.
//    Digits never leave 0..9. The display never shows 00 outside NIGHT.
//  - enable=0: all state holds, including the prescaler, and secTick=0.
//    On return to enable=1, counting resumes from the held prescaler value.
//  - Reset mid-phase: immediate return to the reset values. No partial phase is remembered.
//  - Illegal state encoding: recover to GREEN with BCD(T_GREEN) on the next edge.
//  - Parameters outside 1..99 are a configuration error. Simulation reports $error at time 0.
// CONFIGURATION
//  NIGHT_MODE_EN defined:
//   - Entering NIGHT: nightMode=1 (and enable=1) sampled at an edge moves the FSM to NIGHT on
//     that edge, from any state and without waiting for a tick. On entry the prescaler clears,
//     digits=00 and ledSingle=3'b010.
//   - In NIGHT, each tick toggles the yellow bit, giving 1 s on / 1 s off. Green and red stay 0.
//   - Leaving NIGHT: nightMode=0 sampled in NIGHT moves the FSM to RED, loads BCD(T_RED),
//     sets ledSingle=3'b001 and clears the prescaler, all on the same edge.
//  NIGHT_MODE_EN undefined: nightMode is ignored, the NIGHT state and the blink flag are not
//   built, and behaviour is the 3-state cycle only.
// TESTING  (CLK_PER_SEC=4, T_GREEN=3, T_YELLOW=2, T_RED=12)
//  1 Release reset, enable=1 -> ledSingle=100 with digits 03,02,01, then 010 with digits
//    02,01, then 001 with digits 12,11,...,01, then 100 with digits 03. One change per 4 clks;
//    secTick pulses every 4 clks.
//  2 RED phase, display 10 -> next tick shows 09 (units wrap 0->9, tens 1->0). Display never shows 00.
//  3 Assert enable=0 for 10 clks in mid-GREEN -> outputs and prescaler frozen, secTick=0.
//    After release the next change occurs after the remaining prescaler count.
//  4 Assert rst_n=0 asynchronously during YELLOW (between edges) -> outputs read 100 / 03
//    immediately, before the next clk edge.
//  5 NIGHT_MODE_EN, nightMode=1 during GREEN -> next edge gives 010/00; yellow toggles every
//    4 clks. nightMode=0 -> next edge gives 001/12, then counts down normally.
//  6 Without NIGHT_MODE_EN, toggle nightMode randomly -> sequence identical to scenario 1.

Source files
------------

// File: rtl/traffic_light_ctrl.sv
// Single-direction traffic light sequencer with an internal 1 s prescaler and a BCD countdown display.
// Optional flashing-yellow night state is built only when NIGHT_MODE_EN is defined.
module traffic_light_ctrl #(
    parameter int CLK_PER_SEC = 50_000_000,
    parameter int T_GREEN     = 25,
    parameter int T_YELLOW    = 3,
    parameter int T_RED       = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       nightMode,
    output logic [2:0] ledSingle,
    output logic [3:0] controlLed7Seg1,
    output logic [3:0] controlLed7Seg0,
    output logic       secTick
);

    function automatic logic [7:0] toBcd(input int v);
        toBcd = {4'(v / 10), 4'(v % 10)};
    endfunction

    localparam int              PW         = $clog2(CLK_PER_SEC);
    localparam logic [PW-1:0]   PRE_MAX    = PW'(CLK_PER_SEC - 1);
    localparam logic [7:0]      BCD_GREEN  = toBcd(T_GREEN);
    localparam logic [7:0]      BCD_YELLOW = toBcd(T_YELLOW);
    localparam logic [7:0]      BCD_RED    = toBcd(T_RED);
    localparam logic [2:0]      LAMP_GREEN  = 3'b100;
    localparam logic [2:0]      LAMP_YELLOW = 3'b010;
    localparam logic [2:0]      LAMP_RED    = 3'b001;

    if (CLK_PER_SEC < 2 || T_GREEN < 1 || T_GREEN > 99 || T_YELLOW < 1 || T_YELLOW > 99 ||
        T_RED < 1 || T_RED > 99) begin : gBadParams
        $error("traffic_light_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10
`ifdef NIGHT_MODE_EN
        , NIGHT = 2'b11
`endif
    } lightState_t;

    lightState_t   stateR, stateNextS;
    logic [PW-1:0] prescalerR, prescalerNextS;
    logic [2:0]    ledNextS;
    logic [3:0]    tensNextS, unitsNextS;
    logic          secTickNextS;
    logic          tickS;
`ifdef NIGHT_MODE_EN
    logic          blinkR, blinkNextS;
`else
    logic          unusedNightS;
    assign unusedNightS = nightMode;
`endif

    // Next-state, prescaler and display computation
    always_comb begin
        tickS          = enable && (prescalerR == PRE_MAX);
        stateNextS     = stateR;
        prescalerNextS = prescalerR;
        ledNextS       = ledSingle;
        tensNextS      = controlLed7Seg1;
        unitsNextS     = controlLed7Seg0;
        secTickNextS   = 1'b0;
`ifdef NIGHT_MODE_EN
        blinkNextS     = blinkR;
`endif
        if (enable) begin
            prescalerNextS = tickS ? {PW{1'b0}} : prescalerR + PW'(1);
            secTickNextS   = tickS;
        end else begin
            prescalerNextS = prescalerR;
        end

        case (stateR)
            GREEN, YELLOW, RED: begin
`ifdef NIGHT_MODE_EN
                if (enable && nightMode) begin
                    stateNextS     = NIGHT;
                    prescalerNextS = {PW{1'b0}};
                    ledNextS       = LAMP_YELLOW;
                    tensNextS      = 4'd0;
                    unitsNextS     = 4'd0;
                    blinkNextS     = 1'b1;
                end else
`endif
                if (tickS) begin
                    if (controlLed7Seg1 == 4'd0 && controlLed7Seg0 == 4'd1) begin
                        case (stateR)
                            GREEN: begin
                                stateNextS = YELLOW;
                                ledNextS   = LAMP_YELLOW;
                                {tensNextS, unitsNextS} = BCD_YELLOW;
                            end
                            YELLOW: begin
                                stateNextS = RED;
                                ledNextS   = LAMP_RED;
                                {tensNextS, unitsNextS} = BCD_RED;
                            end
                            default: begin
                                stateNextS = GREEN;
                                ledNextS   = LAMP_GREEN;
                                {tensNextS, unitsNextS} = BCD_GREEN;
                            end
                        endcase
                    end else if (controlLed7Seg0 == 4'd0) begin
                        unitsNextS = 4'd9;
                        tensNextS  = controlLed7Seg1 - 4'd1;
                    end else begin
                        unitsNextS = controlLed7Seg0 - 4'd1;
                    end
                end else begin
                    stateNextS = stateR;
                end
            end
`ifdef NIGHT_MODE_EN
            NIGHT: begin
                if (!enable) begin
                    stateNextS = NIGHT;
                end else if (!nightMode) begin
                    stateNextS     = RED;
                    prescalerNextS = {PW{1'b0}};
                    ledNextS       = LAMP_RED;
                    {tensNextS, unitsNextS} = BCD_RED;
                    blinkNextS     = 1'b0;
                end else if (tickS) begin
                    blinkNextS = ~blinkR;
                    ledNextS   = {1'b0, ~blinkR, 1'b0};
                end else begin
                    stateNextS = NIGHT;
                end
            end
`endif
            default: begin
                // Corrupted state register: restart the cycle cleanly
                stateNextS = GREEN;
                ledNextS   = LAMP_GREEN;
                {tensNextS, unitsNextS} = BCD_GREEN;
            end
        endcase
    end

    // State, prescaler and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateR          <= GREEN;
            prescalerR      <= {PW{1'b0}};
            ledSingle       <= LAMP_GREEN;
            controlLed7Seg1 <= BCD_GREEN[7:4];
            controlLed7Seg0 <= BCD_GREEN[3:0];
            secTick         <= 1'b0;
`ifdef NIGHT_MODE_EN
            blinkR          <= 1'b0;
`endif
        end else begin
            stateR          <= stateNextS;
            prescalerR      <= prescalerNextS;
            ledSingle       <= ledNextS;
            controlLed7Seg1 <= tensNextS;
            controlLed7Seg0 <= unitsNextS;
            secTick         <= secTickNextS;
`ifdef NIGHT_MODE_EN
            blinkR          <= blinkNextS;
`endif
        end
    end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Randomized self-checking bench for traffic_light_ctrl against a seconds-remaining model.
module tb_traffic_light_ctrl;

    localparam int CPS = 4;
    localparam int TG  = 3;
    localparam int TY  = 2;
    localparam int TR  = 12;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       nightMode;
    logic [2:0] ledSingle;
    logic [3:0] controlLed7Seg1;
    logic [3:0] controlLed7Seg0;
    logic       secTick;

    int checks = 0;
    int errors = 0;

    int  dur [3] = '{TG, TY, TR};
    logic [2:0] lamp [3] = '{3'b100, 3'b010, 3'b001};
    int  mCnt, mPhase, mRem;
    bit  mTick, mNight, mBlink;

    traffic_light_ctrl #(
        .CLK_PER_SEC(CPS), .T_GREEN(TG), .T_YELLOW(TY), .T_RED(TR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .nightMode(nightMode),
        .ledSingle(ledSingle), .controlLed7Seg1(controlLed7Seg1),
        .controlLed7Seg0(controlLed7Seg0), .secTick(secTick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mCnt = 0; mPhase = 0; mRem = TG; mTick = 1'b0; mNight = 1'b0; mBlink = 1'b0;
    endtask

    task automatic modelStep();
        if (!rst_n) begin
            modelReset();
        end else if (enable) begin
            mTick = (mCnt == CPS - 1);
            mCnt  = mTick ? 0 : mCnt + 1;
`ifdef NIGHT_MODE_EN
            if (!mNight && nightMode) begin
                mNight = 1'b1; mCnt = 0; mBlink = 1'b1;
            end else if (mNight && !nightMode) begin
                mNight = 1'b0; mCnt = 0; mPhase = 2; mRem = TR; mBlink = 1'b0;
            end else if (mNight) begin
                if (mTick) mBlink = ~mBlink;
            end else
`endif
            if (mTick) begin
                if (mRem == 1) begin
                    mPhase = (mPhase + 1) % 3;
                    mRem   = dur[mPhase];
                end else begin
                    mRem = mRem - 1;
                end
            end
        end else begin
            mTick = 1'b0;
        end
    endtask

    // Per-cycle comparison of every output against the model
    initial begin
        logic [2:0] expLed;
        logic [7:0] expDig;
        modelReset();
        forever begin
            @(posedge clk);
            modelStep();
            #1;
            expLed = mNight ? {1'b0, mBlink, 1'b0} : lamp[mPhase];
            expDig = mNight ? 8'h00 : {4'(mRem / 10), 4'(mRem % 10)};
            chk("led", {29'd0, ledSingle}, {29'd0, expLed});
            chk("digits", {24'd0, controlLed7Seg1, controlLed7Seg0}, {24'd0, expDig});
            chk("secTick", {31'd0, secTick}, {31'd0, mTick});
        end
    end

    initial begin
        bit found;
        rst_n = 1'b0; enable = 1'b0; nightMode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_led", {29'd0, ledSingle}, 32'h4);
        chk("rst_digits", {24'd0, controlLed7Seg1, controlLed7Seg0}, 32'h03);
        chk("rst_secTick", {31'd0, secTick}, 32'h0);

        @(negedge clk); rst_n = 1'b1; enable = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("first_tick_digits", {24'd0, controlLed7Seg1, controlLed7Seg0}, 32'h02);
        chk("first_tick_pulse", {31'd0, secTick}, 32'h1);
        repeat (8) @(posedge clk); #1;
        chk("yellow_led", {29'd0, ledSingle}, 32'h2);
        chk("yellow_digits", {24'd0, controlLed7Seg1, controlLed7Seg0}, 32'h02);
        repeat (8) @(posedge clk); #1;
        chk("red_led", {29'd0, ledSingle}, 32'h1);
        chk("red_digits", {24'd0, controlLed7Seg1, controlLed7Seg0}, 32'h12);
        repeat (12) @(posedge clk); #1;
        chk("bcd_wrap_10_09", {24'd0, controlLed7Seg1, controlLed7Seg0}, 32'h09);
        repeat (36) @(posedge clk); #1;
        chk("green_again_led", {29'd0, ledSingle}, 32'h4);
        chk("green_again_digits", {24'd0, controlLed7Seg1, controlLed7Seg0}, 32'h03);

        // Freeze mid-green with two prescaler counts already taken
        repeat (2) @(posedge clk);
        @(negedge clk); enable = 1'b0;
        repeat (10) @(posedge clk); #1;
        chk("frozen_digits", {24'd0, controlLed7Seg1, controlLed7Seg0}, 32'h03);
        chk("frozen_secTick", {31'd0, secTick}, 32'h0);
        @(negedge clk); enable = 1'b1;
        @(posedge clk); #1;
        chk("resume_no_tick", {24'd0, controlLed7Seg1, controlLed7Seg0}, 32'h03);
        @(posedge clk); #1;
        chk("resume_tick_digits", {24'd0, controlLed7Seg1, controlLed7Seg0}, 32'h02);
        chk("resume_tick_pulse", {31'd0, secTick}, 32'h1);

        // Asynchronous reset between edges while yellow
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (mPhase == 1 && !mNight) found = 1'b1;
        end
        chk("reached_yellow", {31'd0, found}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_led", {29'd0, ledSingle}, 32'h4);
        chk("async_rst_digits", {24'd0, controlLed7Seg1, controlLed7Seg0}, 32'h03);
        chk("async_rst_secTick", {31'd0, secTick}, 32'h0);
        modelReset();
        @(negedge clk); rst_n = 1'b1;

        // Random enable gaps and nightMode toggling
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            enable = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 39) == 0) nightMode = ~nightMode;
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                #1 modelReset();
                @(negedge clk); rst_n = 1'b1;
            end
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
